// File: rtl/delta_gen_seq_pkg.sv
// delta_gen_seq_pkg: shared defaults and FSM state encodings for the delta generator
package delta_gen_seq_pkg;
    localparam int DATA_W_DEF      = 16;
    localparam int FRAC_W_DEF      = 8;
    localparam int N_MAX_DEF       = 32;
    localparam int LEAKY_SHIFT_DEF = 3;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_MAC   = 2'd1,
        S_SCALE = 2'd2,
        S_OUT   = 2'd3
    } state_t;
endpackage

// File: rtl/delta_gen_seq_if.sv
// delta_gen_seq_if: request, operand-read and result handshake bundle of the delta generator
interface delta_gen_seq_if
    import delta_gen_seq_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int N_MAX  = N_MAX_DEF
);
    localparam int ADDR_W = $clog2(N_MAX);

    logic                     start;
    logic                     is_last;
    logic                     z_neg;
    logic        [ADDR_W:0]   fan_out;
    logic signed [DATA_W-1:0] y_val;
    logic signed [DATA_W-1:0] desired_val;
    logic                     rd_en;
    logic        [ADDR_W-1:0] rd_addr;
    logic signed [DATA_W-1:0] wt_data;
    logic signed [DATA_W-1:0] d_in_data;
    logic signed [DATA_W-1:0] d_out;
    logic                     d_valid;
    logic                     d_ready;
    logic                     busy;

    modport master (
        output start, is_last, z_neg, fan_out, y_val, desired_val, wt_data, d_in_data, d_ready,
        input  rd_en, rd_addr, d_out, d_valid, busy
    );

    modport slave (
        input  start, is_last, z_neg, fan_out, y_val, desired_val, wt_data, d_in_data, d_ready,
        output rd_en, rd_addr, d_out, d_valid, busy
    );
endinterface

// File: rtl/delta_gen_seq_mac_unit.sv
// mac_unit: signed multiply-accumulate with synchronous clear and enable
module mac_unit #(
    parameter int DATA_W = 16,
    parameter int ACC_W  = 38
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_clr,
    input  logic                     i_en,
    input  logic signed [DATA_W-1:0] i_a,
    input  logic signed [DATA_W-1:0] i_b,
    output logic signed [ACC_W-1:0]  o_acc
);
    logic signed [2*DATA_W-1:0] w_prod;
    logic signed [ACC_W-1:0]    r_acc;

    always_comb w_prod = i_a * i_b;

    always_ff @(posedge clk) begin
        if (rst || i_clr)
            r_acc <= '0;
        else if (i_en)
            r_acc <= r_acc + {{(ACC_W-2*DATA_W){w_prod[2*DATA_W-1]}}, w_prod};
    end

    assign o_acc = r_acc;
endmodule

// File: rtl/delta_gen_seq.sv
// delta_gen_seq: sequential backprop delta generator (MAC over fan-out, leaky-ReLU scale, saturate)
module delta_gen_seq
    import delta_gen_seq_pkg::*;
#(
    parameter int DATA_W      = DATA_W_DEF,
    parameter int FRAC_W      = FRAC_W_DEF,
    parameter int N_MAX       = N_MAX_DEF,
    parameter int LEAKY_SHIFT = LEAKY_SHIFT_DEF
) (
    input logic            clk,
    input logic            rst,
    delta_gen_seq_if.slave bus
);
    localparam int ADDR_W = $clog2(N_MAX);
    localparam int ACC_W  = 2*DATA_W + ADDR_W + 1;

    state_t                   r_state;
    logic        [ADDR_W:0]   r_cnt;
    logic        [ADDR_W:0]   r_fan;
    logic                     r_last;
    logic                     r_zneg;
    logic signed [DATA_W-1:0] r_y;
    logic signed [DATA_W-1:0] r_des;
    logic                     r_rd_en;
    logic        [ADDR_W-1:0] r_rd_addr;
    logic signed [DATA_W-1:0] r_dout;
    logic                     r_dvalid;

    logic signed [ACC_W-1:0]  w_acc;
    logic signed [ACC_W-1:0]  w_hid;
    logic signed [ACC_W-1:0]  w_pre;
    logic signed [ACC_W-1:0]  w_shr;
    logic signed [ACC_W-1:0]  w_lk;
    logic signed [DATA_W:0]   w_diff;
    logic        [DATA_W-1:0] w_sat;
    logic                     w_ok;
    logic        [ADDR_W:0]   w_nxt;
    logic                     w_clr;
    logic                     w_en;

    // step c>=1 consumes the operands requested at step c-1
    assign w_clr = (r_state == S_IDLE) && bus.start;
    assign w_en  = (r_state == S_MAC) && (r_cnt != '0);

    mac_unit #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_mac (
        .clk   (clk),
        .rst   (rst),
        .i_clr (w_clr),
        .i_en  (w_en),
        .i_a   (bus.wt_data),
        .i_b   (bus.d_in_data),
        .o_acc (w_acc)
    );

    // signed shifts kept in separate signed terms so the muxes cannot turn them logical
    always_comb begin
        w_diff = {r_y[DATA_W-1], r_y} - {r_des[DATA_W-1], r_des};
        w_hid  = w_acc >>> FRAC_W;
        w_pre  = r_last ? {{(ACC_W-DATA_W-1){w_diff[DATA_W]}}, w_diff} : w_hid;
        w_shr  = w_pre >>> LEAKY_SHIFT;
        w_lk   = r_zneg ? w_shr : w_pre;
        w_ok   = (&w_lk[ACC_W-1:DATA_W-1]) || !(|w_lk[ACC_W-1:DATA_W-1]);
        w_sat  = w_ok ? w_lk[DATA_W-1:0] : {w_lk[ACC_W-1], {(DATA_W-1){~w_lk[ACC_W-1]}}};
        w_nxt  = r_cnt + (ADDR_W+1)'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_fan     <= '0;
            r_last    <= 1'b0;
            r_zneg    <= 1'b0;
            r_y       <= '0;
            r_des     <= '0;
            r_rd_en   <= 1'b0;
            r_rd_addr <= '0;
            r_dout    <= '0;
            r_dvalid  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: if (bus.start) begin
                    r_fan     <= bus.fan_out;
                    r_last    <= bus.is_last;
                    r_zneg    <= bus.z_neg;
                    r_y       <= bus.y_val;
                    r_des     <= bus.desired_val;
                    r_cnt     <= '0;
                    r_rd_en   <= !bus.is_last && (bus.fan_out != '0);
                    r_rd_addr <= '0;
                    r_state   <= bus.is_last ? S_SCALE : S_MAC;
                end
                S_MAC: begin
                    r_cnt     <= w_nxt;
                    r_rd_en   <= w_nxt < r_fan;
                    r_rd_addr <= w_nxt[ADDR_W-1:0];
                    if (r_cnt == r_fan)
                        r_state <= S_SCALE;
                end
                S_SCALE: begin
                    r_dout   <= w_sat;
                    r_dvalid <= 1'b1;
                    r_state  <= S_OUT;
                end
                S_OUT: if (bus.d_ready) begin
                    r_dvalid <= 1'b0;
                    r_state  <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.rd_en   = r_rd_en;
    assign bus.rd_addr = r_rd_addr;
    assign bus.d_out   = r_dout;
    assign bus.d_valid = r_dvalid;
    assign bus.busy    = (r_state != S_IDLE);
endmodule

// File: tb/tb_delta_gen_seq.sv
// tb_delta_gen_seq: directed-vector bench for delta_gen_seq with an operand memory model
module tb_delta_gen_seq;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int          n_vec = 0;
    int          n_err = 0;
    int          rd_cnt = 0;
    logic [15:0] wt_mem [32];
    logic [15:0] din_mem [32];

    delta_gen_seq_if #(.DATA_W(16), .N_MAX(32)) bus ();

    delta_gen_seq dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // operand memory: one-cycle read latency, junk on cycles without a read
    always @(posedge clk) begin
        if (bus.rd_en)
            rd_cnt <= rd_cnt + 1;
        bus.wt_data   <= bus.rd_en ? wt_mem[bus.rd_addr]  : 16'($urandom);
        bus.d_in_data <= bus.rd_en ? din_mem[bus.rd_addr] : 16'($urandom);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_mem(input logic [15:0] wt, input logic [15:0] din);
        for (int i = 0; i < 32; i++) begin
            wt_mem[i]  = wt;
            din_mem[i] = din;
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, ".dout"},    32'($unsigned(bus.d_out)), 32'h0);
        chk({tag, ".dvalid"},  32'(bus.d_valid), 32'h0);
        chk({tag, ".rd_en"},   32'(bus.rd_en), 32'h0);
        chk({tag, ".rd_addr"}, 32'(bus.rd_addr), 32'h0);
        chk({tag, ".busy"},    32'(bus.busy), 32'h0);
    endtask

    task automatic do_op(input string tag, input logic last, input logic zn, input int fan,
                         input logic [15:0] y, input logic [15:0] des,
                         input logic [15:0] exp_d, input int exp_lat, input int exp_rd);
        int e;
        int rd0;
        @(negedge clk);
        bus.is_last     = last;
        bus.z_neg       = zn;
        bus.fan_out     = 6'(fan);
        bus.y_val       = y;
        bus.desired_val = des;
        bus.start       = 1'b1;
        rd0 = rd_cnt;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        e = 1;
        while (!bus.d_valid && e < 100) begin
            @(posedge clk);
            #1;
            e++;
        end
        chk({tag, ".lat"},  32'(e), 32'(exp_lat));
        chk({tag, ".dout"}, 32'($unsigned(bus.d_out)), 32'(exp_d));
        chk({tag, ".rd"},   32'(rd_cnt - rd0), 32'(exp_rd));
    endtask

    task automatic finish_op(input string tag);
        @(negedge clk);
        bus.d_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.d_ready = 1'b0;
        chk({tag, ".done_valid"}, 32'(bus.d_valid), 32'h0);
        chk({tag, ".done_busy"},  32'(bus.busy), 32'h0);
    endtask

    initial begin
        int e;
        bus.start       = 1'b0;
        bus.is_last     = 1'b0;
        bus.z_neg       = 1'b0;
        bus.fan_out     = '0;
        bus.y_val       = '0;
        bus.desired_val = '0;
        bus.d_ready     = 1'b0;
        set_mem(16'h0100, 16'h0080);
        repeat (2) @(posedge clk);
        #1;
        chk_reset("por");
        @(negedge clk);
        rst = 1'b0;

        do_op("h4", 0, 0, 4, 16'h0, 16'h0, 16'h0200, 7, 4);        finish_op("h4");
        do_op("h4z", 0, 1, 4, 16'h0, 16'h0, 16'h0040, 7, 4);       finish_op("h4z");
        do_op("h0", 0, 0, 0, 16'h0, 16'h0, 16'h0000, 3, 0);        finish_op("h0");
        do_op("last", 1, 1, 5, 16'h0100, 16'h0300, 16'hFFC0, 2, 0); finish_op("last");
        do_op("lrnd", 1, 1, 0, 16'h0001, 16'h0002, 16'hFFFF, 2, 0); finish_op("lrnd");
        do_op("lwide", 1, 0, 0, 16'h7FFF, 16'h8000, 16'h7FFF, 2, 0); finish_op("lwide");
        do_op("lwz", 1, 1, 0, 16'h7FFF, 16'h8000, 16'h1FFF, 2, 0);  finish_op("lwz");

        set_mem(16'h7FFF, 16'h7FFF);
        do_op("satp", 0, 0, 32, 16'h0, 16'h0, 16'h7FFF, 35, 32);   finish_op("satp");
        set_mem(16'h8000, 16'h7FFF);
        do_op("satn", 0, 0, 32, 16'h0, 16'h0, 16'h8000, 35, 32);   finish_op("satn");

        // 2*1 + (-1)*0.5 + 1.5*(-2) = -1.5
        set_mem(16'h0000, 16'h0000);
        wt_mem[0] = 16'h0200; din_mem[0] = 16'h0100;
        wt_mem[1] = 16'hFF00; din_mem[1] = 16'h0080;
        wt_mem[2] = 16'h0180; din_mem[2] = 16'hFE00;
        do_op("mix", 0, 0, 3, 16'h0, 16'h0, 16'hFE80, 6, 3);        finish_op("mix");
        do_op("mixz", 0, 1, 3, 16'h0, 16'h0, 16'hFFD0, 6, 3);       finish_op("mixz");

        set_mem(16'h0100, 16'h0080);
        do_op("bp", 0, 0, 4, 16'h0, 16'h0, 16'h0200, 7, 4);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            bus.start = ~bus.start;
            @(posedge clk);
            #1;
            chk("bp.hold",  32'($unsigned(bus.d_out)), 32'h0200);
            chk("bp.valid", 32'(bus.d_valid), 32'h1);
        end
        @(negedge clk);
        bus.d_ready = 1'b1;
        bus.start   = 1'b1;
        @(posedge clk);
        #1;
        chk("bp.idle_busy",  32'(bus.busy), 32'h0);
        chk("bp.idle_valid", 32'(bus.d_valid), 32'h0);
        @(negedge clk);
        bus.d_ready = 1'b0;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        chk("bp.restart", 32'(bus.busy), 32'h1);
        e = 1;
        while (!bus.d_valid && e < 100) begin
            @(posedge clk);
            #1;
            e++;
        end
        chk("bp2.lat",  32'(e), 32'd7);
        chk("bp2.dout", 32'($unsigned(bus.d_out)), 32'h0200);
        finish_op("bp2");

        @(negedge clk);
        bus.is_last = 1'b0;
        bus.z_neg   = 1'b0;
        bus.fan_out = 6'd4;
        bus.start   = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("abort.addr", 32'(bus.rd_addr), 32'h2);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk_reset("abort");
        @(negedge clk);
        rst = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("abort.noout", 32'(bus.d_valid), 32'h0);
        do_op("rr", 0, 0, 4, 16'h0, 16'h0, 16'h0200, 7, 4);        finish_op("rr");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/delta_gen_seq.md
DELTA_GEN_SEQ -- requirements
Module: delta_gen_seq

Interface
REQ-001 Parameter DATA_W, default 16: signed fixed-point word width of all data ports.
REQ-002 Parameter FRAC_W, default 8: fractional bits of every data word (Q8.8 at defaults).
REQ-003 Parameter N_MAX, default 32: maximum fan-out, i.e. the number of next-layer neurons summed; ADDR_W = clog2(N_MAX).
REQ-004 Parameter LEAKY_SHIFT, default 3: leaky-ReLU negative-slope divisor, applied as 2^LEAKY_SHIFT.
REQ-005 Clock and reset are fixed: one clock, and reset is synchronous and active-high.
REQ-006 CLK  in  1  sole clock; all state updates on its rising edge.
REQ-007 RST  in  1  synchronous, active-high reset.
REQ-008 start  in  1  request for one delta computation; sampled only in IDLE.
REQ-009 is_last  in  1  1 = output layer (error term), 0 = hidden layer (backpropagated sum); sampled with start.
REQ-010 z_neg  in  1  sign of the neuron's pre-activation (1 = negative); sampled with start.
REQ-011 fan_out  in  ADDR_W+1  number of terms to sum, 0..N_MAX; sampled with start.
REQ-012 y_val, desired_val  in  DATA_W each  neuron output and target; sampled with start.
REQ-013 rd_en, rd_addr  out  1, ADDR_W  operand read request and its index.
REQ-014 wT_data, d_in_data  in  DATA_W each  operand pair for rd_addr; valid exactly 1 cycle after rd_en.
REQ-015 d_out  out  DATA_W  generated delta; d_valid  out  1; d_ready  in  1.
REQ-016 busy  out  1  high in every state except IDLE.

Function
REQ-017 The FSM SHALL have four states: IDLE, MAC, SCALE and OUT.
REQ-018 From IDLE, start=1 SHALL capture all sampled inputs, clear the accumulator and go to MAC if is_last=0, or to SCALE if is_last=1.
REQ-019 MAC SHALL run for fan_out+1 cycles, with step counter c = 0..fan_out.
REQ-020 In MAC, rd_en=1 and rd_addr=c while c<fan_out; otherwise rd_en=0.
REQ-021 In MAC, for c>=1 the accumulator SHALL add wT_data*d_in_data, where the product is signed 2*DATA_W bits and the accumulator is 2*DATA_W+ADDR_W+1 bits with no overflow possible.
REQ-022 After MAC, the FSM SHALL go to SCALE.
REQ-023 In SCALE, the hidden-layer value SHALL be acc>>>FRAC_W, and the last-layer value SHALL be y_val-desired_val computed at DATA_W+1 bits.
REQ-024 In SCALE, if z_neg=1 the value SHALL be arithmetically shifted right by LEAKY_SHIFT (rounding toward minus infinity); otherwise it passes unchanged.
REQ-025 In SCALE, the result SHALL be saturated to [-2^(DATA_W-1), 2^(DATA_W-1)-1], registered into d_out, and the FSM goes to OUT.
REQ-026 In OUT, d_valid=1 and d_out SHALL be held stable until d_ready=1, then the FSM returns to IDLE with d_valid=0 on the next cycle.
REQ-027 Latency: d_valid SHALL rise fan_out+3 edges after the start edge (hidden layer) or 2 edges after it (last layer).
REQ-028 fan_out=0 SHALL issue no reads and produce d_out=0.
REQ-029 start SHALL be ignored outside IDLE, including in the OUT cycle that completes the handshake; the next start is accepted no earlier than the following cycle.
REQ-030 Operand data SHALL be ignored whenever rd_en was 0 in the previous cycle.

Reset
REQ-031 With RST=1 at a clock edge the block SHALL enter IDLE, with d_out=0, d_valid=0, rd_en=0, rd_addr=0, busy=0 and the accumulator cleared.
REQ-032 RST SHALL take priority over start and d_ready, and SHALL abort any in-flight computation without producing an output.

Structure
REQ-033 DATA_W, FRAC_W and LEAKY_SHIFT defaults, the N_MAX default (equal to the network's maximum layer width), and the FSM state encodings SHALL live in the shared library_file.v include.
REQ-034 One sub-module, mac_unit (signed multiply plus accumulate with clear and enable), SHALL be instantiated; saturation and scaling remain in delta_gen_seq.

Verification
REQ-035 Hidden layer, fan_out=4, all wT=0x0100, all d_in=0x0080, z_neg=0 -> d_out=0x0200, with d_valid rising 7 edges after start.
REQ-036 Same stimulus with z_neg=1 -> d_out=0x0040; with fan_out=0 -> no rd_en pulses and d_out=0x0000 after 3 edges.
REQ-037 Last layer, y_val=0x0100, desired_val=0x0300, z_neg=1 -> d_out=0xFFC0 after 2 edges; the rd_en pulse count is zero.
REQ-038 Saturation: fan_out=32, wT=d_in=0x7FFF -> d_out=0x7FFF; wT=0x8000, d_in=0x7FFF -> d_out=0x8000.
REQ-039 Backpressure: d_ready held low for 5 cycles in OUT with start pulsing -> d_out stable, no restart; d_ready=1 -> IDLE, then a new start is accepted the next cycle.
REQ-040 RST asserted at MAC step c=2 -> next cycle IDLE with all outputs at reset values; a following start with REQ-035 stimulus -> 0x0200.
